// File: rtl/csr_exec_unit.sv
// csr_exec_unit: two-stage machine-mode CSR execution unit.
// S0 captures the RS issue packet and the rs1 operand; S1 performs the CSR read-modify-write
// and registers the completion broadcast (CSR_done/CSR_phy) the reservation station snoops.
// Optional feature macro: CSR_CYCLE_COUNTER_EN adds mcycle (0xB00) / mcycleh (0xB80).
module csr_exec_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter int unsigned PHY_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [129:0]     issue_pkt,
  output logic [PHY_W-1:0] prf_raddr,
  input  logic [31:0]      prf_rdata,
  input  logic             exception_sig,
  input  logic [31:0]      exc_pc,
  input  logic [31:0]      exc_cause,
  input  logic             mret_sig,
  output logic             CSR_done,
  output logic [PHY_W-1:0] CSR_phy,
  output logic [31:0]      CSR_result,
  output logic [31:0]      CSR_inst_num,
  output logic [31:0]      mtvec_out,
  output logic [31:0]      mepc_out
);

  localparam logic [11:0] AddrMstatus  = 12'h300;
  localparam logic [11:0] AddrMtvec    = 12'h305;
  localparam logic [11:0] AddrMscratch = 12'h340;
  localparam logic [11:0] AddrMepc     = 12'h341;
  localparam logic [11:0] AddrMcause   = 12'h342;
`ifdef CSR_CYCLE_COUNTER_EN
  localparam logic [11:0] AddrMcycle   = 12'hB00;
  localparam logic [11:0] AddrMcycleh  = 12'hB80;
`endif

  localparam logic [3:0] OpRw = 4'h1;
  localparam logic [3:0] OpRs = 4'h2;
  localparam logic [3:0] OpRc = 4'h3;

  // Issue packet fields
  logic             pkt_vld;
  logic [PHY_W-1:0] pkt_op1;
  logic [31:0]      pkt_inst;
  logic [PHY_W-1:0] pkt_rd;
  logic [3:0]       pkt_op;
  logic             pkt_src2;
  logic [31:0]      pkt_csr_data;
  logic [11:0]      pkt_addr;
  logic [31:0]      pkt_imm;

  assign {pkt_vld, pkt_op1, pkt_inst, pkt_rd, pkt_op, pkt_src2, pkt_csr_data, pkt_addr,
          pkt_imm} = issue_pkt;

  // The RS-supplied csr_data snapshot is stale by design; the local file is authoritative.
  logic unused_pkt;
  assign unused_pkt = ^{pkt_csr_data, pkt_imm[31:5]};

  assign prf_raddr = pkt_op1;

  logic flush;
  assign flush = exception_sig | mret_sig;

  // S1 stage registers
  logic             s1_valid_q;
  logic [PHY_W-1:0] s1_rd_q;
  logic [31:0]      s1_inst_q;
  logic [3:0]       s1_op_q;
  logic [11:0]      s1_addr_q;
  logic [31:0]      s1_src_q;
  logic             s1_imm_zero_q;

  // CSR file state
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
`ifdef CSR_CYCLE_COUNTER_EN
  logic [63:0] mcycle_q, mcycle_d;
`endif

  // Completion outputs
  logic             done_q;
  logic [PHY_W-1:0] phy_q;
  logic [31:0]      result_q;
  logic [31:0]      inst_q;

  logic [31:0] csr_old;
  logic [31:0] csr_new;
  logic        csr_we;
  logic        s1_fire;

  assign s1_fire = s1_valid_q & ~flush;

  // S0 -> S1 capture; a flush in the same cycle drops the incoming packet
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= pkt_vld & ~flush;
    end
    if (pkt_vld) begin
      s1_rd_q       <= pkt_rd;
      s1_inst_q     <= pkt_inst;
      s1_op_q       <= pkt_op;
      s1_addr_q     <= pkt_addr;
      s1_src_q      <= pkt_src2 ? {27'b0, pkt_imm[4:0]} : prf_rdata;
      s1_imm_zero_q <= pkt_src2 & (pkt_imm[4:0] == 5'd0);
    end
  end

  // CSR read mux; unimplemented addresses read zero
  always_comb begin
    csr_old = 32'h0;
    case (s1_addr_q)
      AddrMstatus:  csr_old = {24'h0, mpie_q, 3'b0, mie_q, 3'b0};
      AddrMtvec:    csr_old = mtvec_q;
      AddrMscratch: csr_old = mscratch_q;
      AddrMepc:     csr_old = mepc_q;
      AddrMcause:   csr_old = mcause_q;
`ifdef CSR_CYCLE_COUNTER_EN
      AddrMcycle:   csr_old = mcycle_q[31:0];
      AddrMcycleh:  csr_old = mcycle_q[63:32];
`endif
      default:      csr_old = 32'h0;
    endcase
  end

  // Read-modify-write value and write enable; immediate-zero set/clear stays side-effect free
  always_comb begin
    csr_new = csr_old;
    csr_we  = 1'b0;
    case (s1_op_q)
      OpRw: begin
        csr_new = s1_src_q;
        csr_we  = 1'b1;
      end
      OpRs: begin
        csr_new = csr_old | s1_src_q;
        csr_we  = ~s1_imm_zero_q;
      end
      OpRc: begin
        csr_new = csr_old & ~s1_src_q;
        csr_we  = ~s1_imm_zero_q;
      end
      default: begin
        csr_new = csr_old;
        csr_we  = 1'b0;
      end
    endcase
    csr_we = csr_we & s1_fire;
  end

  // CSR file next state: op write, then trap / mret side effects (trap has priority)
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (csr_we) begin
      case (s1_addr_q)
        AddrMstatus: begin
          mie_d  = csr_new[3];
          mpie_d = csr_new[7];
        end
        AddrMtvec:    mtvec_d    = csr_new;
        AddrMscratch: mscratch_d = csr_new;
        AddrMepc:     mepc_d     = {csr_new[31:2], 2'b00};
        AddrMcause:   mcause_d   = csr_new;
        default:      ;
      endcase
    end
    if (exception_sig) begin
      mepc_d   = {exc_pc[31:2], 2'b00};
      mcause_d = exc_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_sig) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  // CSR file registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

`ifdef CSR_CYCLE_COUNTER_EN
  // Cycle counter: a write to a word replaces that word's increment for the cycle
  always_comb begin
    mcycle_d = mcycle_q + 64'd1;
    if (csr_we && (s1_addr_q == AddrMcycle)) begin
      mcycle_d = {mcycle_q[63:32], csr_new};
    end else if (csr_we && (s1_addr_q == AddrMcycleh)) begin
      mcycle_d = {csr_new, mcycle_q[31:0] + 32'd1};
    end
  end

  // Cycle counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle_q <= 64'h0;
    end else begin
      mcycle_q <= mcycle_d;
    end
  end
`endif

  // Completion broadcast; tag/result hold their last value between pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q   <= 1'b0;
      phy_q    <= '0;
      result_q <= 32'h0;
      inst_q   <= 32'h0;
    end else begin
      done_q <= s1_fire;
      if (s1_fire) begin
        phy_q    <= s1_rd_q;
        result_q <= csr_old;
        inst_q   <= s1_inst_q;
      end
    end
  end

  assign CSR_done     = done_q;
  assign CSR_phy      = phy_q;
  assign CSR_result   = result_q;
  assign CSR_inst_num = inst_q;
  assign mtvec_out    = mtvec_q;
  assign mepc_out     = mepc_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Bench for csr_exec_unit: directed scenarios with literal expectations, then randomized
// traffic (ops, traps, mrets, resets) checked every cycle against a behavioural CSR model.
// Honours CSR_CYCLE_COUNTER_EN the same way the design does.
module tb_csr_exec_unit;

  logic         clk;
  logic         reset;
  logic [129:0] issue_pkt;
  logic [7:0]   prf_raddr;
  logic [31:0]  prf_rdata;
  logic         exception_sig;
  logic [31:0]  exc_pc;
  logic [31:0]  exc_cause;
  logic         mret_sig;
  logic         CSR_done;
  logic [7:0]   CSR_phy;
  logic [31:0]  CSR_result;
  logic [31:0]  CSR_inst_num;
  logic [31:0]  mtvec_out;
  logic [31:0]  mepc_out;

  int total = 0;
  int bad   = 0;

  csr_exec_unit dut (
    .clk          (clk),
    .reset        (reset),
    .issue_pkt    (issue_pkt),
    .prf_raddr    (prf_raddr),
    .prf_rdata    (prf_rdata),
    .exception_sig(exception_sig),
    .exc_pc       (exc_pc),
    .exc_cause    (exc_cause),
    .mret_sig     (mret_sig),
    .CSR_done     (CSR_done),
    .CSR_phy      (CSR_phy),
    .CSR_result   (CSR_result),
    .CSR_inst_num (CSR_inst_num),
    .mtvec_out    (mtvec_out),
    .mepc_out     (mepc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          live = 0;
  bit          m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
`ifdef CSR_CYCLE_COUNTER_EN
  logic [63:0] m_cyc;
`endif
  // op accepted last cycle, executes this cycle
  bit          p_vld = 0;
  bit          p_nowr;
  logic [11:0] p_addr;
  logic [3:0]  p_op;
  logic [31:0] p_src, p_inst;
  logic [7:0]  p_rd;
  // expected outputs after the current edge
  bit          e_done = 0;
  logic [7:0]  e_phy;
  logic [31:0] e_res, e_inst;
  bit          t_flush, t_wr;
  logic [31:0] t_old, t_new;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return {24'h0, m_mpie, 3'b000, m_mie, 3'b000};
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
`ifdef CSR_CYCLE_COUNTER_EN
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] v);
    case (a)
      12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
      12'h305: m_mtvec    = v;
      12'h340: m_mscratch = v;
      12'h341: m_mepc     = v & 32'hFFFF_FFFC;
      12'h342: m_mcause   = v;
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_mie = 0; m_mpie = 0; m_mtvec = 32'h100; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
`ifdef CSR_CYCLE_COUNTER_EN
      m_cyc = 64'h0;
`endif
      p_vld = 0; e_done = 0; e_phy = 0; e_res = 0; e_inst = 0;
      live = 1;
    end else begin
      t_flush = exception_sig | mret_sig;
      t_wr    = 0;
      t_new   = 0;
      e_done  = 0;
      if (p_vld && !t_flush) begin
        t_old = m_read(p_addr);
        case (p_op)
          4'h1: begin t_new = p_src;          t_wr = 1;       end
          4'h2: begin t_new = t_old | p_src;  t_wr = !p_nowr; end
          4'h3: begin t_new = t_old & ~p_src; t_wr = !p_nowr; end
          default: t_new = t_old;
        endcase
        e_done = 1; e_phy = p_rd; e_res = t_old; e_inst = p_inst;
        if (t_wr) m_write(p_addr, t_new);
      end
`ifdef CSR_CYCLE_COUNTER_EN
      if (t_wr && p_addr == 12'hB00)      m_cyc = {m_cyc[63:32], t_new};
      else if (t_wr && p_addr == 12'hB80) m_cyc = {t_new, m_cyc[31:0] + 32'd1};
      else                                m_cyc = m_cyc + 64'd1;
`endif
      if (exception_sig) begin
        m_mepc = exc_pc & 32'hFFFF_FFFC; m_mcause = exc_cause; m_mpie = m_mie; m_mie = 0;
      end else if (mret_sig) begin
        m_mie = m_mpie; m_mpie = 1;
      end
      p_vld = issue_pkt[129] && !t_flush;
      if (p_vld) begin
        p_inst = issue_pkt[120:89];
        p_rd   = issue_pkt[88:81];
        p_op   = issue_pkt[80:77];
        p_addr = issue_pkt[43:32];
        p_src  = issue_pkt[76] ? {27'h0, issue_pkt[4:0]} : prf_rdata;
        p_nowr = issue_pkt[76] && (issue_pkt[4:0] == 5'd0);
      end
    end
  end

  // compare process, away from the active edge
  always @(negedge clk) begin
    if (live) begin
      chk("done", 32'(CSR_done), 32'(e_done));
      if (e_done) begin
        chk("phy", 32'(CSR_phy), 32'(e_phy));
        chk("result", CSR_result, e_res);
        chk("inst_num", CSR_inst_num, e_inst);
      end
      chk("mtvec_out", mtvec_out, m_mtvec);
      chk("mepc_out", mepc_out, m_mepc);
      chk("prf_raddr", 32'(prf_raddr), 32'(issue_pkt[128:121]));
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] inst_ctr = 32'h1000;

  function automatic logic [129:0] mk(input bit v, input logic [7:0] rd, input logic [3:0] aop,
                                      input bit s2, input logic [11:0] addr,
                                      input logic [31:0] imm);
    logic [7:0]  op1;
    logic [31:0] junk;
    op1  = 8'($urandom());
    junk = $urandom();
    return {v, op1, inst_ctr, rd, aop, s2, junk, addr, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_pkt = mk(1'b0, 8'($urandom()), 4'h1, 1'b0, 12'h340, $urandom());
    prf_rdata = $urandom();
    step();
  endtask

  task automatic issue(input logic [3:0] aop, input logic [11:0] addr, input bit s2,
                       input logic [31:0] imm, input logic [31:0] rdata, input logic [7:0] rd);
    issue_pkt = mk(1'b1, rd, aop, s2, addr, imm);
    prf_rdata = rdata;
    inst_ctr  = inst_ctr + 32'd1;
    step();
    issue_pkt[129] = 1'b0;
  endtask

  // single op, then check its completion two cycles after issue
  task automatic op_check(input string name, input logic [3:0] aop, input logic [11:0] addr,
                          input bit s2, input logic [31:0] imm, input logic [31:0] rdata,
                          input logic [31:0] exp);
    issue(aop, addr, s2, imm, rdata, 8'h40);
    idle();
    chk({name, "_done"}, 32'(CSR_done), 32'h1);
    chk(name, CSR_result, exp);
  endtask

  logic [11:0] addrs[8] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7C0,
                            12'hB00, 12'hB80};
  logic [31:0] rimm;

  initial begin
    reset = 1; exception_sig = 0; mret_sig = 0; exc_pc = 0; exc_cause = 0;
    issue_pkt = '0; prf_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    chk("rst_done", 32'(CSR_done), 32'h0);
    chk("rst_phy", 32'(CSR_phy), 32'h0);
    chk("rst_result", CSR_result, 32'h0);
    chk("rst_inst", CSR_inst_num, 32'h0);
    chk("rst_mtvec", mtvec_out, 32'h0000_0100);
    chk("rst_mepc", mepc_out, 32'h0);

    // mscratch write then back-to-back read
    issue(4'h1, 12'h340, 1'b0, 32'h0, 32'hDEAD_BEEF, 8'h21);
    chk("rw_not_yet", 32'(CSR_done), 32'h0);
    issue(4'h2, 12'h340, 1'b1, 32'h0, 32'h0, 8'h22);
    chk("rw_done", 32'(CSR_done), 32'h1);
    chk("rw_phy", 32'(CSR_phy), 32'h21);
    chk("rw_old", CSR_result, 32'h0);
    idle();
    chk("b2b_phy", 32'(CSR_phy), 32'h22);
    chk("b2b_read", CSR_result, 32'hDEAD_BEEF);
    idle();
    chk("single_pulse", 32'(CSR_done), 32'h0);

    // CSRRSI / CSRRCI on mstatus back-to-back
    issue(4'h2, 12'h300, 1'b1, 32'h8, 32'h0, 8'h31);
    issue(4'h3, 12'h300, 1'b1, 32'h8, 32'h0, 8'h32);
    chk("rsi_old", CSR_result, 32'h0);
    idle();
    chk("rci_old", CSR_result, 32'h8);
    op_check("mstatus_clr", 4'h2, 12'h300, 1'b1, 32'h0, 32'h0, 32'h0);

    // unimplemented CSR
    op_check("unimpl_w", 4'h1, 12'h7C0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0);
    op_check("unimpl_r", 4'h2, 12'h7C0, 1'b1, 32'h0, 32'h0, 32'h0);

    // op flushed by a trap one cycle after issue
    issue(4'h1, 12'h340, 1'b0, 32'h0, 32'h1234_5678, 8'h50);
    exception_sig = 1; exc_pc = 32'h80; exc_cause = 32'd2;
    step();
    exception_sig = 0;
    chk("flush_no_done", 32'(CSR_done), 32'h0);
    chk("trap_mepc", mepc_out, 32'h80);
    op_check("flush_kept", 4'h2, 12'h340, 1'b1, 32'h0, 32'h0, 32'hDEAD_BEEF);
    op_check("trap_mcause", 4'h2, 12'h342, 1'b1, 32'h0, 32'h0, 32'd2);
    op_check("trap_mie0", 4'h2, 12'h300, 1'b1, 32'h0, 32'h0, 32'h0);

    // MIE=1, trap, mret
    op_check("set_mie", 4'h2, 12'h300, 1'b1, 32'h8, 32'h0, 32'h0);
    exception_sig = 1; exc_pc = 32'h200; exc_cause = 32'd11;
    step();
    exception_sig = 0;
    op_check("after_trap", 4'h2, 12'h300, 1'b1, 32'h0, 32'h0, 32'h80);
    mret_sig = 1;
    step();
    mret_sig = 0;
    op_check("after_mret", 4'h2, 12'h300, 1'b1, 32'h0, 32'h0, 32'h88);

    // cycle counter carry
    issue(4'h1, 12'hB00, 1'b0, 32'h0, 32'hFFFF_FFFF, 8'h60);
    idle();
`ifdef CSR_CYCLE_COUNTER_EN
    op_check("mcycleh_carry", 4'h2, 12'hB80, 1'b1, 32'h0, 32'h0, 32'h1);
`else
    op_check("mcycleh_absent", 4'h2, 12'hB80, 1'b1, 32'h0, 32'h0, 32'h0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rimm = $urandom();
      if ($urandom_range(0, 2) == 0) rimm[4:0] = 5'd0;
      issue_pkt = mk($urandom_range(0, 9) < 6, 8'($urandom()), 4'($urandom_range(0, 5)),
                     1'($urandom()), addrs[$urandom_range(0, 7)], rimm);
      inst_ctr      = inst_ctr + 32'd1;
      prf_rdata     = $urandom();
      exception_sig = ($urandom_range(0, 99) < 4);
      mret_sig      = ($urandom_range(0, 99) < 4);
      exc_pc        = $urandom();
      exc_cause     = $urandom();
      reset         = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 0; exception_sig = 0; mret_sig = 0;
    repeat (4) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
